// File: rtl/mem_stream_adapter.sv
// mem_stream_adapter: bridges a valid/ready request stream onto a req/gnt
// memory port and returns memory responses as a valid/ready stream.
// Grants are credit-limited to NUM_OUTSTANDING so every response can be
// held in the internal in-order buffer while the consumer stalls.
module mem_stream_adapter #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned NUM_OUTSTANDING = 2,
    parameter int unsigned CNT_WIDTH       = $clog2(NUM_OUTSTANDING + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic                    req_we_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_be_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic [DATA_WIDTH-1:0]   rsp_data_o,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [CNT_WIDTH-1:0]    outstanding_o,
    output logic                    err_o
);

    localparam int unsigned PTR_WIDTH = (NUM_OUTSTANDING > 1) ? $clog2(NUM_OUTSTANDING) : 1;
    localparam logic [CNT_WIDTH-1:0] CREDIT_MAX = CNT_WIDTH'(NUM_OUTSTANDING);
    localparam logic [PTR_WIDTH-1:0] PTR_LAST   = PTR_WIDTH'(NUM_OUTSTANDING - 1);

    logic [CNT_WIDTH-1:0]  outstanding_q;
    logic [CNT_WIDTH-1:0]  inflight_q;
    logic [CNT_WIDTH-1:0]  occupancy_q;
    logic [PTR_WIDTH-1:0]  wr_ptr_q;
    logic [PTR_WIDTH-1:0]  rd_ptr_q;
    logic [DATA_WIDTH-1:0] buf_q [NUM_OUTSTANDING];

    logic credit_ok;
    logic handshake;
    logic rsp_push;
    logic rsp_pop;

    // Request path is zero-latency pass-through gated by available credit.
    always_comb begin
        credit_ok   = (outstanding_q < CREDIT_MAX);
        mem_req_o   = req_valid_i & credit_ok;
        req_ready_o = mem_gnt_i & credit_ok;
        mem_addr_o  = req_addr_i;
        mem_we_o    = req_we_i;
        mem_wdata_o = req_wdata_i;
        mem_be_o    = req_be_i;
        handshake   = req_valid_i & req_ready_o;
        // A response is legal if something is in flight or is being granted now;
        // anything else is stray data from a grant we do not know about.
        rsp_push    = mem_rvalid_i & ((inflight_q != '0) | handshake);
        err_o       = mem_rvalid_i & (inflight_q == '0) & ~handshake;
        rsp_valid_o = (occupancy_q != '0);
        rsp_pop     = rsp_valid_o & rsp_ready_i;
        rsp_data_o  = buf_q[rd_ptr_q];
        outstanding_o = outstanding_q;
    end

    // Credit usage: granted transactions whose response has not yet been popped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else begin
            case ({handshake, rsp_pop})
                2'b10:   outstanding_q <= outstanding_q + CNT_WIDTH'(1);
                2'b01:   outstanding_q <= outstanding_q - CNT_WIDTH'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // In-flight count: granted transactions whose memory response is still pending.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= '0;
        end else begin
            case ({handshake, rsp_push})
                2'b10:   inflight_q <= inflight_q + CNT_WIDTH'(1);
                2'b01:   inflight_q <= inflight_q - CNT_WIDTH'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // In-order response buffer: circular storage with occupancy count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occupancy_q <= '0;
            for (int unsigned i = 0; i < NUM_OUTSTANDING; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            if (rsp_push) begin
                buf_q[wr_ptr_q] <= mem_rdata_i;
                wr_ptr_q        <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_WIDTH'(1);
            end
            if (rsp_pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_WIDTH'(1);
            end
            case ({rsp_push, rsp_pop})
                2'b10:   occupancy_q <= occupancy_q + CNT_WIDTH'(1);
                2'b01:   occupancy_q <= occupancy_q - CNT_WIDTH'(1);
                default: occupancy_q <= occupancy_q;
            endcase
        end
    end

endmodule
